// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 multiply / divide unit with HI/LO result
// registers. One iteration per cycle, 32 iterations, then one sign-fix cycle.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  // Per-operation context latched at start; neg flags are already gated by
  // signedness, so unsigned ops never see a sign correction.
  typedef struct packed {
    logic is_div;
    logic neg_a;
    logic neg_b;
  } ctx_t;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;     // mul: {partial product, multiplier}; div: {rem, dividend/quotient}
  logic [31:0] b_mag;   // multiplicand or divisor magnitude
  ctx_t        ctx;

  logic        op_valid, op_signed, op_is_div;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag_in;
  logic        accept;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_tmp, div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  logic [63:0] prod_fix;
  logic [31:0] q_raw, r_raw;
  logic [31:0] res_hi, res_lo;

  assign busy = (state != S_IDLE);

  // Decode request and form operand magnitudes.
  always_comb begin
    op_valid  = 1'b0;
    op_signed = 1'b0;
    op_is_div = 1'b0;
    case (op)
      OP_MULT:  begin op_valid = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_valid = 1'b1; end
      OP_DIV:   begin op_valid = 1'b1; op_signed = 1'b1; op_is_div = 1'b1; end
      OP_DIVU:  begin op_valid = 1'b1; op_is_div = 1'b1; end
      default:  ;
    endcase
    a_neg    = op_signed & op1[31];
    b_neg    = op_signed & op2[31];
    a_mag    = a_neg ? -op1 : op1;
    b_mag_in = b_neg ? -op2 : op2;
    accept   = (state == S_IDLE) && start && op_valid;
  end

  // One iteration step for each operation class.
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    // Restoring division: bring in the next dividend bit, subtract if it fits.
    // A zero divisor always "fits", giving an all-ones quotient and the
    // dividend as remainder.
    div_tmp  = {acc[63:32], acc[31]};
    div_diff = div_tmp - {1'b0, b_mag};
    div_ge   = (div_tmp >= {1'b0, b_mag});
    div_next = {(div_ge ? div_diff[31:0] : div_tmp[31:0]), acc[30:0], div_ge};
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod_fix = (ctx.neg_a ^ ctx.neg_b) ? -acc : acc;
    q_raw    = acc[31:0];
    r_raw    = acc[63:32];
    if (ctx.is_div) begin
      res_hi = ctx.neg_a ? -r_raw : r_raw;
      if (b_mag == 32'd0)
        res_lo = 32'hFFFF_FFFF;
      else
        res_lo = (ctx.neg_a ^ ctx.neg_b) ? -q_raw : q_raw;
    end else begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end
  end

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      acc   <= 64'd0;
      b_mag <= 32'd0;
      ctx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_CALC;
            cnt        <= 5'd31;
            acc        <= {32'd0, a_mag};
            b_mag      <= b_mag_in;
            ctx.is_div <= op_is_div;
            ctx.neg_a  <= a_neg;
            ctx.neg_b  <= b_neg;
          end
        end
        S_CALC: begin
          acc <= ctx.is_div ? div_next : mul_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // HI/LO: result write on leaving FIX; direct writes only in IDLE and only
  // when no operation is being accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == S_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == S_IDLE && !accept) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: driver pushes expected {hi,lo,done cycle},
// a negedge monitor pops and checks on every done pulse.
module tb_hilo_muldiv;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] op1 = 32'd0, op2 = 32'd0, wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  hilo_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       nm;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ehi, elo;
    string       nm;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[9];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: checks every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check32({e.nm, "_hi"}, hi, e.hi);
          check32({e.nm, "_lo"}, lo, e.lo);
          check_int({e.nm, "_done_cycle"}, cyc, e.due);
          check_int({e.nm, "_busy_cycles"}, busy_cnt, 33);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called #1 after a rising edge; the start is taken on the next edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string nm,
                       input bit expect_done);
    start = 1'b1; op = o; op1 = a; op2 = b;
    if (expect_done) sb.push_back('{hi: ehi, lo: elo, due: cyc + 34, nm: nm});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $display("FAIL %s_timeout: got no done in 60 cycles expected done", nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'b0000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3"};
    vt[1] = '{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vt[2] = '{4'b1101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    vt[3] = '{4'b1100, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, "divu_by0"};
    vt[4] = '{4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"};
    vt[5] = '{4'b1101, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0_neg"};
    vt[6] = '{4'b0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_minsq"};
    vt[7] = '{4'b1100, 32'd100,       32'd7,         32'd2,         32'h0000_000E, "divu_100d7"};
    vt[8] = '{4'b0000, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7xm1"};

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Vector table, each op started in the previous op's done cycle
    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].ehi, vt[i].elo, vt[i].nm, 1'b1);
      if (i == 0) begin
        repeat (4) begin @(posedge clk); #1; end
        check32("calc_busy", {31'd0, busy}, 32'd1);
        check32("calc_hi_hold", hi, 32'd0);
        check32("calc_lo_hold", lo, 32'd0);
        // start pulse mid-CALC must be ignored
        start = 1'b1; op = 4'b1100; op1 = 32'd1; op2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(vt[i].nm);
    end

    // MTHI alone, then MTHI+MTLO together
    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    mthi = 1'b0;
    check32("mthi_hi", hi, 32'h1234_5678);
    check32("mthi_lo_kept", lo, 32'hFFFF_FFF9);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check32("mthilo_hi", hi, 32'hCAFE_F00D);
    check32("mthilo_lo", lo, 32'hCAFE_F00D);

    // MTLO during CALC is dropped
    issue(4'b1001, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3x5", 1'b1);
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    mtlo = 1'b0;
    check32("mtlo_busy_lo", lo, 32'hCAFE_F00D);
    wait_done("multu_3x5");

    // start + MTLO in the same cycle: start wins
    mtlo = 1'b1; wdata = 32'hAAAA_AAAA;
    issue(4'b1100, 32'd100, 32'd7, 32'd2, 32'h0000_000E, "divu_mtlo", 1'b1);
    mtlo = 1'b0;
    check32("start_mtlo_lo", lo, 32'd15);
    check32("start_mtlo_busy", {31'd0, busy}, 32'd1);
    wait_done("divu_mtlo");

    // Invalid op is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 4'b0001; op1 = 32'd9; op2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    check32("bad_op_busy", {31'd0, busy}, 32'd0);
    check32("bad_op_hi", hi, 32'd2);

    // Reset in CALC cycle 10 aborts with no done
    issue(4'b0000, 32'd5, 32'd5, 32'd0, 32'd25, "mult_abort", 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    check32("abort_done", {31'd0, done}, 32'd0);
    repeat (40) begin @(posedge clk); #1; end

    issue(4'b1101, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7dm2", 1'b1);
    wait_done("div_7dm2");

    repeat (2) @(posedge clk);
    #1;
    check_int("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a multiply/divide; sampled only in IDLE.
REQ-005 op  input  4  operation code: 4'b0000 MULT, 4'b1001 MULTU, 4'b1101 DIV, 4'b1100 DIVU; all other codes are invalid.
REQ-006 op1  input  32  multiplicand or dividend; latched when start is accepted.
REQ-007 op2  input  32  multiplier or divisor; latched when start is accepted.
REQ-008 mthi  input  1  write wdata to HI (MTHI).
REQ-009 mtlo  input  1  write wdata to LO (MTLO).
REQ-010 wdata  input  32  data for mthi/mtlo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse: the hi/lo outputs now hold a new result.
REQ-013 hi  output  32  HI register (MFHI source).
REQ-014 lo  output  32  LO register (MFLO source).

Function
REQ-015 The state machine SHALL have three states: IDLE, CALC, FIX; busy = (state != IDLE).
REQ-016 In IDLE, start with a valid op SHALL latch op, operand magnitudes and sign flags, load a 5-bit iteration counter with 31, and enter CALC.
REQ-017 In IDLE, start with an invalid op SHALL be ignored: state, hi and lo are unchanged.
REQ-018 CALC SHALL perform one iteration per cycle for exactly 32 cycles.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring division producing a 32-bit quotient and a 32-bit remainder.
  - CALC SHALL exit to FIX when the counter reaches 0.
REQ-019 FIX SHALL apply sign correction, write hi/lo on the edge leaving FIX, and return to IDLE.
REQ-020 done SHALL be registered and high exactly one cycle: the first IDLE cycle after FIX, when hi/lo already show the result.
REQ-021 Latency: with start accepted on edge E0, busy SHALL be high for 33 cycles and done SHALL be high in cycle 34.
REQ-022 A new start SHALL be accepted in the same cycle that done is high.
REQ-023 MULT/MULTU result SHALL be {hi,lo} = full 64-bit product.
  - MULT uses two's-complement operands.
  - MULTU uses unsigned operands.
REQ-024 DIV/DIVU result SHALL be lo = quotient and hi = remainder.
  - DIV quotient truncates toward zero.
  - DIV remainder takes the sign of the dividend.
REQ-025 Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF SHALL give lo = 32'h8000_0000, hi = 0.
REQ-026 Divide by zero (DIV or DIVU) SHALL take the normal latency and give lo = 32'hFFFF_FFFF, hi = op1.
REQ-027 mthi/mtlo in IDLE SHALL update hi/lo with wdata on the next edge; both may be asserted together.
REQ-028 mthi/mtlo while busy SHALL be ignored.
REQ-029 If start (valid op) and mthi/mtlo are asserted in the same IDLE cycle, start SHALL win and the writes are dropped.
REQ-030 start while busy SHALL be ignored; there is no queueing.
REQ-031 hi/lo SHALL hold their values throughout CALC and FIX; there are no partial updates.

Reset
REQ-032 When rst_n is low on a rising edge, the block SHALL set:
  - state = IDLE
  - hi = 0, lo = 0
  - busy = 0, done = 0
  - iteration counter and internal accumulators cleared
REQ-033 Reset asserted mid-operation (CALC or FIX) SHALL abort the operation with no hi/lo write and no done pulse.
REQ-034 The first start SHALL be accepted on the first edge where rst_n is high.

Verification
REQ-035 MULT op1 = 32'hFFFF_FFFE (-2), op2 = 3 -> done in cycle 34, hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFFA; busy high 33 cycles.
REQ-036 MULTU op1 = op2 = 32'hFFFF_FFFF -> hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
REQ-037 DIV op1 = -7, op2 = 2 -> lo = 32'hFFFF_FFFD, hi = 32'hFFFF_FFFF; DIVU op1 = 7, op2 = 0 -> lo = 32'hFFFF_FFFF, hi = 7.
REQ-038 Back-to-back: second start in the done cycle -> accepted, second done exactly 34 cycles later; start pulsed mid-CALC -> ignored.
REQ-039 mthi wdata = 32'h1234_5678 in IDLE -> hi updated next cycle; mtlo during CALC -> lo unchanged; start + mtlo in the same cycle -> mtlo dropped.
REQ-040 rst_n low at CALC cycle 10 -> busy = 0, hi = lo = 0 next cycle, no done pulse; next start completes normally.
